// File: rtl/mem_dp_param.sv
// mem_dp_param: simple-dual-port SRAM model (one write port, one read port).
// Features: per-byte write enables, 1- or 2-cycle read latency, and selectable
// same-address read-during-write result. After reset, a sweep writes zero to
// every word before any port request is accepted.
module mem_dp_param #(
    parameter  int DATA_W     = 32,
    parameter  int DEPTH      = 1024,
    parameter  int RD_LATENCY = 1,
    parameter  int RDW_MODE   = 0,
    localparam int BE_W       = DATA_W / 8,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_mem_wr_en,
    input  logic [ADDR_W-1:0] in_mem_wr_addr,
    input  logic [DATA_W-1:0] in_mem_wr_data,
    input  logic [BE_W-1:0]   in_mem_wr_byte_en,
    input  logic              in_mem_rd_en,
    input  logic [ADDR_W-1:0] in_mem_rd_addr,
    output logic [DATA_W-1:0] out_mem_rd_data,
    output logic              out_mem_rd_valid,
    output logic              out_mem_init_busy,
    output logic              out_mem_req_drop
);

    // DEPTH widened by one bit so that every address value can be compared
    // against it, including DEPTH that is not a power of two.
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] sweep_cnt_reg;
    logic              busy_reg;
    logic              req_drop_reg;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_accept;
    logic              rd_accept;
    logic              init_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] rd_idx;

    logic              rd_valid_reg;
    logic              rd_zero_reg;
    logic [DATA_W-1:0] rd_word;

    // Port requests are only honoured once the sweep has finished.
    assign wr_in_range = ({1'b0, in_mem_wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, in_mem_rd_addr} < DEPTH_W);
    assign wr_accept   = reset_n && (state_reg == ST_RUN) && in_mem_wr_en && wr_in_range;
    assign rd_accept   = reset_n && (state_reg == ST_RUN) && in_mem_rd_en;
    assign init_we     = reset_n && (state_reg == ST_INIT);

    // The single physical write port is shared by the sweep and the user port.
    assign mem_we    = init_we || wr_accept;
    assign mem_waddr = init_we ? sweep_cnt_reg : in_mem_wr_addr;
    assign mem_wdata = init_we ? '0 : in_mem_wr_data;
    assign mem_be    = init_we ? {BE_W{1'b1}} : in_mem_wr_byte_en;

    // Out-of-range reads still look up a legal word; the zero flag masks it.
    assign rd_idx = rd_in_range ? in_mem_rd_addr : '0;

    // Init/run controller: sweep counter, busy flag and dropped-request pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= ST_INIT;
            sweep_cnt_reg <= '0;
            busy_reg      <= 1'b1;
            req_drop_reg  <= 1'b0;
        end else begin
            req_drop_reg <= (in_mem_wr_en || in_mem_rd_en) && busy_reg;
            case (state_reg)
                ST_INIT: begin
                    sweep_cnt_reg <= sweep_cnt_reg + ADDR_W'(1);
                    if (sweep_cnt_reg == LAST_ADDR) begin
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    busy_reg <= 1'b0;
                end
                default: begin
                    state_reg <= ST_INIT;
                    busy_reg  <= 1'b1;
                end
            endcase
        end
    end

    // First read stage control: valid strobe and out-of-range zero flag.
    // The zero flag is forced on in reset so the output reads 0 until the
    // first accepted read replaces the (uninitialised) lane registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_valid_reg <= 1'b0;
            rd_zero_reg  <= 1'b1;
        end else begin
            rd_valid_reg <= rd_accept;
            if (rd_accept) begin
                rd_zero_reg <= !rd_in_range;
            end
        end
    end

    // One byte-wide RAM per lane, so each byte enable maps onto its own array.
    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] lane_q_reg;
            logic [7:0] lane_byp_reg;
            logic       lane_hit_reg;
            logic       lane_hit_next;

            // In new-data mode a same-address write on the read edge
            // overrides this lane's stored byte.
            assign lane_hit_next = (RDW_MODE == 1) && wr_accept
                                   && (in_mem_wr_addr == in_mem_rd_addr)
                                   && in_mem_wr_byte_en[gi];

            // Lane write, shared between sweep and user port.
            always_ff @(posedge clock) begin
                if (mem_we && mem_be[gi]) begin
                    mem_lane[mem_waddr] <= mem_wdata[8*gi +: 8];
                end
            end

            // Registered lane read (read-first), plus the bypass byte for
            // new-data read-during-write.
            always_ff @(posedge clock) begin
                if (rd_accept) begin
                    lane_q_reg   <= mem_lane[rd_idx];
                    lane_byp_reg <= in_mem_wr_data[8*gi +: 8];
                    lane_hit_reg <= lane_hit_next;
                end
            end

            assign rd_word[8*gi +: 8] = rd_zero_reg  ? 8'h00 :
                                        lane_hit_reg ? lane_byp_reg : lane_q_reg;
        end

        if (RD_LATENCY == 1) begin : g_lat1
            assign out_mem_rd_data  = rd_word;
            assign out_mem_rd_valid = rd_valid_reg;
        end else begin : g_lat2
            logic [DATA_W-1:0] rd_data_reg;
            logic              rd_valid2_reg;

            // Second read stage: data only updates on a valid, so it holds
            // its last value between reads.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    rd_data_reg   <= '0;
                    rd_valid2_reg <= 1'b0;
                end else begin
                    rd_valid2_reg <= rd_valid_reg;
                    if (rd_valid_reg) begin
                        rd_data_reg <= rd_word;
                    end
                end
            end

            assign out_mem_rd_data  = rd_data_reg;
            assign out_mem_rd_valid = rd_valid2_reg;
        end
    endgenerate

    assign out_mem_init_busy = busy_reg;
    assign out_mem_req_drop  = req_drop_reg;

endmodule

// File: tb/tb_mem_dp_param.sv
// tb_mem_dp_param: four parameter sets of mem_dp_param run side by side, each
// with its own random stimulus, array-based reference model and scoreboard.
module tb_mem_dp_param;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input int cfg, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL cfg%0d %s actual=%h expected=%h cyc=%0d", cfg, name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
        localparam int DEP = (gi < 2) ? 16 : 12;
        localparam int LAT = (gi % 2) + 1;
        localparam int RDW = (gi == 1 || gi == 2) ? 1 : 0;
        localparam int AW  = $clog2(DEP);

        logic          rst_n = 1'b0;
        logic          wr_en = 1'b0;
        logic          rd_en = 1'b0;
        logic [AW-1:0] wr_addr = '0;
        logic [AW-1:0] rd_addr = '0;
        logic [31:0]   wr_data = '0;
        logic [3:0]    be = '0;
        logic [31:0]   rd_data;
        logic          rd_valid;
        logic          busy;
        logic          drop;

        logic [31:0] model_mem [DEP];
        exp_t        sb[$];
        int          n_run = 0;
        bit          exp_busy;
        bit          exp_drop;
        bit          rst_edge;
        logic [31:0] last_data = '0;

        mem_dp_param #(
            .DATA_W(32),
            .DEPTH(DEP),
            .RD_LATENCY(LAT),
            .RDW_MODE(RDW)
        ) dut (
            .clock(clk),
            .reset_n(rst_n),
            .in_mem_wr_en(wr_en),
            .in_mem_wr_addr(wr_addr),
            .in_mem_wr_data(wr_data),
            .in_mem_wr_byte_en(be),
            .in_mem_rd_en(rd_en),
            .in_mem_rd_addr(rd_addr),
            .out_mem_rd_data(rd_data),
            .out_mem_rd_valid(rd_valid),
            .out_mem_init_busy(busy),
            .out_mem_req_drop(drop)
        );

        // Expected busy/drop: busy lasts DEPTH clean edges after reset release.
        initial forever begin
            @(posedge clk);
            exp_drop = rst_n && (wr_en || rd_en) && (n_run < DEP);
            rst_edge = !rst_n;
            if (!rst_n) n_run = 0;
            else if (n_run < DEP) n_run++;
            exp_busy = (n_run < DEP);
        end

        // Monitor: compares outputs against model and scoreboard each cycle.
        initial forever begin
            exp_t e;
            @(negedge clk);
            chk(gi, "busy", {31'b0, busy}, {31'b0, exp_busy});
            chk(gi, "req_drop", {31'b0, drop}, {31'b0, exp_drop});
            if (rst_edge) begin
                chk(gi, "rst_valid", {31'b0, rd_valid}, 32'd0);
                chk(gi, "rst_data", rd_data, 32'd0);
                sb.delete();
                last_data = '0;
            end else if (rd_valid) begin
                chk(gi, "valid_expected", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk(gi, "rd_time", 32'(cyc), 32'(e.due));
                    chk(gi, "rd_data", rd_data, e.data);
                    last_data = e.data;
                    $display("cfg%0d cyc=%0d read data=%h expected=%h", gi, cyc, rd_data, e.data);
                end
            end else begin
                chk(gi, "rd_hold", rd_data, last_data);
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    chk(gi, "missing_valid", {31'b0, rd_valid}, 32'd1);
                    e = sb.pop_front();
                end
            end
        end

        // Drive one cycle of requests; update the model if they will be accepted.
        task automatic issue(input bit w, input int wa, input logic [31:0] wd,
                             input logic [3:0] b, input bit r, input int ra);
            exp_t x;
            wr_en   = w;
            wr_addr = AW'(wa);
            wr_data = wd;
            be      = b;
            rd_en   = r;
            rd_addr = AW'(ra);
            if (rst_n && n_run >= DEP) begin
                if (r) begin
                    x.data = '0;
                    if (ra < DEP) x.data = model_mem[ra];
                    if (RDW == 1 && w && wa == ra && wa < DEP) x.data = merge(x.data, wd, b);
                    x.due = cyc + LAT;
                    sb.push_back(x);
                end
                if (w && wa < DEP) model_mem[wa] = merge(model_mem[wa], wd, b);
            end
            @(negedge clk);
        endtask

        task automatic reset_and_sweep(input int rst_cycles);
            rst_n = 1'b0;
            for (int i = 0; i < rst_cycles; i++)
                issue(1, $urandom_range(0, 15), $urandom, 4'hF, 1, $urandom_range(0, 15));
            for (int a = 0; a < DEP; a++) model_mem[a] = '0;
            rst_n = 1'b1;
            // Requests held high for the whole sweep must all be dropped.
            for (int i = 0; i < DEP; i++)
                issue(1, $urandom_range(0, 15), $urandom, 4'($urandom), 1, $urandom_range(0, 15));
            // Read every address, including unused codes above DEPTH-1.
            for (int a = 0; a < 16; a++) issue(0, 0, 0, 4'h0, 1, a);
        endtask

        initial begin
            int wa;
            int ra;
            reset_and_sweep(2);
            // Byte enables.
            issue(1, 5, 32'hAABBCCDD, 4'hF, 0, 0);
            issue(1, 5, 32'h11223344, 4'b0101, 0, 0);
            issue(0, 0, 0, 4'h0, 1, 5);
            // Same-address read-during-write, then read back.
            issue(1, 7, 32'hDEADBEEF, 4'hF, 1, 7);
            issue(0, 0, 0, 4'h0, 1, 7);
            // Back-to-back reads.
            issue(1, 0, 32'd10, 4'hF, 0, 0);
            issue(1, 1, 32'd11, 4'hF, 0, 0);
            issue(1, 2, 32'd12, 4'hF, 0, 0);
            issue(0, 0, 0, 4'h0, 1, 0);
            issue(0, 0, 0, 4'h0, 1, 1);
            issue(0, 0, 0, 4'h0, 1, 2);
            // Address 13 (out of range when DEPTH=12), then address 1.
            issue(1, 13, 32'h5A5A5A5A, 4'hF, 0, 0);
            issue(0, 0, 0, 4'h0, 1, 13);
            issue(0, 0, 0, 4'h0, 1, 1);
            // Zero byte enable is a no-op, with a colliding read.
            issue(1, 3, 32'hFFFFFFFF, 4'h0, 1, 3);
            issue(0, 0, 0, 4'h0, 1, 3);
            // Random traffic with frequent address collisions.
            for (int i = 0; i < 200; i++) begin
                wa = $urandom_range(0, 15);
                ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
                issue(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), ra);
            end
            // Reset with reads in flight, then everything must read as zero.
            issue(0, 0, 0, 4'h0, 1, 5);
            issue(0, 0, 0, 4'h0, 1, 0);
            reset_and_sweep(1);
            for (int i = 0; i < 4; i++) issue(0, 0, 0, 4'h0, 0, 0);
            chk(gi, "sb_drained", 32'(sb.size()), 32'd0);
            done_cnt++;
        end
    end

    initial begin
        while (done_cnt < 4 && cyc < 20000) @(negedge clk);
        if (done_cnt < 4) begin
            checks++;
            failures++;
            $display("FAIL timeout done_cnt=%0d cyc=%0d", done_cnt, cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_dp_param.md
# mem_dp_param

Parametrised simple-dual-port (1 write, 1 read) SRAM model with per-byte write enables and configurable read latency. It defines read-during-write behaviour and adds a self-clearing initialisation sweep after reset. It is the drop-in memory model for blocks that need concurrent read and write access or a width/depth other than 32x1024. All ports are synchronous to a single clock.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of 8; BE_W = DATA_W/8 is derived.
- DEPTH, 1024: number of words; any value ≥ 2; ADDR_W = $clog2(DEPTH) is derived.
- RD_LATENCY, 1: read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0: same-address read-during-write result; 0 = old data, 1 = new (merged) data.

- clock  in  1  sole clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- in_mem_wr_en  in  1  write request, sampled on posedge.
- in_mem_wr_addr  in  ADDR_W  write word address.
- in_mem_wr_data  in  DATA_W  write data.
- in_mem_wr_byte_en  in  BE_W  bit i enables byte i (bits 8i+7:8i).
- in_mem_rd_en  in  1  read request, sampled on posedge.
- in_mem_rd_addr  in  ADDR_W  read word address.
- out_mem_rd_data  out  DATA_W  read data, qualified by out_mem_rd_valid.
- out_mem_rd_valid  out  1  one-cycle pulse per accepted read.
- out_mem_init_busy  out  1  high while the clear sweep runs; requests are not accepted.
- out_mem_req_drop  out  1  one-cycle pulse: a wr_en or rd_en arrived while busy and was discarded.

## Operation
- States: INIT and RUN.
  - Reset: state=INIT, sweep counter=0.
  - INIT: one word per cycle is written to all-zero (all bytes), at address = counter. The counter increments each cycle.
  - INIT → RUN on the edge that writes address DEPTH-1.
  - RUN is held until reset_n=0.
- Request handling in INIT:
  - wr_en and rd_en are ignored. Memory is not written by the port, and no rd_valid is produced.
  - out_mem_req_drop is registered: it is 1 in the cycle after any cycle in which (wr_en | rd_en) & busy.
- Write in RUN:
  - On posedge with wr_en=1 and wr_addr<DEPTH, byte i of mem[wr_addr] takes wr_data byte i if byte_en[i]=1. Otherwise byte i keeps its old value.
  - byte_en=0 is a no-op.
  - wr_addr ≥ DEPTH: the write is discarded silently.
- Read in RUN:
  - On posedge with rd_en=1, the word at rd_addr is captured into the read pipeline.
  - rd_addr ≥ DEPTH returns all-zero data, with valid still asserted.
- Read-during-write, same address on the same edge:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the byte-merged post-write word.
  - Different addresses: the ports are fully independent.
- Pipeline and reset:
  - Reads may issue every cycle (full throughput). No backpressure is applied.
  - Reset mid-operation flushes all in-flight reads: valid=0, with no pulse afterwards. It also restarts the sweep at address 0.
  - Memory contents are not reset directly; they are cleared only by the sweep.

## Timing
- Reset values, on the first posedge with reset_n=0:
  - out_mem_rd_data=0
  - out_mem_rd_valid=0
  - out_mem_init_busy=1
  - out_mem_req_drop=0
  - pipeline valids=0
- Sweep timing:
  - The first posedge with reset_n=1 clears address 0.
  - busy stays 1 for exactly DEPTH cycles after reset release.
  - busy goes 0 on the edge that clears DEPTH-1.
- Request acceptance:
  - A request is accepted on the first posedge at which busy=0 is being presented.
- Read latency (read sampled at edge N):
  - RD_LATENCY=1: data and valid are updated by edge N, and visible in cycle N..N+1.
  - RD_LATENCY=2: data and valid are updated by edge N+1.
- rd_valid is high for exactly one cycle per accepted read.
- out_mem_rd_data holds its last value while valid=0.
- A write at edge N is visible to a read sampled at edge N+1 in either mode.

## Test plan
- Init sweep, DEPTH=16:
  - Release reset, then hold wr_en=rd_en=1 while busy.
  - Required: busy=1 for 16 cycles; req_drop pulses each of those cycles; no valid.
  - Then read all 16 addresses: every word is 0x00000000.
- Byte enables:
  - Write 0xAABBCCDD at addr 5 with be=4'hF, then 0x11223344 with be=4'b0101.
  - Required: reading addr 5 returns 0xAA22CC44.
- Read-during-write, same address on the same edge:
  - Addr 7 holds 0x0; write 0xDEADBEEF (be=4'hF) while reading addr 7.
  - Required: RDW_MODE=0 returns 0x00000000; RDW_MODE=1 returns 0xDEADBEEF.
- Back-to-back reads, RD_LATENCY=2:
  - Read addrs 0,1,2 on consecutive edges, preloaded with 10,11,12.
  - Required: valid high for 3 consecutive cycles, starting one cycle later than with RD_LATENCY=1; data 10,11,12 in order.
- Reset mid-operation:
  - Issue reads in flight, then drive reset_n=0 for 1 cycle.
  - Required: no valid pulse afterwards; busy=1 for DEPTH cycles; previously written data reads back as 0.
- Out-of-range address, DEPTH=12, ADDR_W=4:
  - Write to addr 13, then read addr 13 and addr 1.
  - Required: addr 13 returns 0 with valid; addr 1 is unchanged.
